// File: rtl/skeleton_pkg.sv
// Shared state encoding, header ID and word-formatting helpers for the
// multi-input/multi-output math test skeleton.
package skeleton_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LAUNCH,
    ST_WAIT
  } state_e;

  localparam logic [3:0] HEAD_ID = 4'd5;

  // The status word sits at the all-ones address of the host bus.
  function automatic logic [31:0] status_addr(input int unsigned adr_w);
    return (32'd1 << adr_w) - 32'd1;
  endfunction

  // n ones in the LSBs; fills the unused low bits of an MSB-aligned data word.
  function automatic logic [63:0] pad_ones(input int unsigned n);
    return (64'd1 << n) - 64'd1;
  endfunction

endpackage

// File: rtl/skeleton_regfile.sv
// Input/output word RAM with host address decode and a registered read mux.
// Input words are host-writable only while the sequencer allows it.
module skeleton_regfile
  import skeleton_pkg::*;
#(
  parameter int BITWIDTH_IN  = 8,
  parameter int BITWIDTH_OUT = 8,
  parameter int BITWIDTH_SYS = 16,
  parameter int BITWIDTH_ADR = 6,
  parameter int SIZE_INPUT   = 4,
  parameter int SIZE_OUTPUT  = 2,
  parameter int STAT_W       = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                rnw,
  input  logic                                wr_allow,
  input  logic                                cap_en,
  input  logic [BITWIDTH_ADR-1:0]             adr,
  input  logic [BITWIDTH_SYS-1:0]             data_in,
  input  logic [SIZE_OUTPUT*BITWIDTH_OUT-1:0] cap_vec,
  input  logic [STAT_W-1:0]                   status,
  output logic [SIZE_INPUT*BITWIDTH_IN-1:0]   in_vec,
  output logic [BITWIDTH_SYS-1:0]             data_out
);

  localparam logic [BITWIDTH_ADR-1:0] STATUS_ADR = BITWIDTH_ADR'(status_addr(BITWIDTH_ADR));
  localparam int SH_IN  = BITWIDTH_SYS - BITWIDTH_IN;
  localparam int SH_OUT = BITWIDTH_SYS - BITWIDTH_OUT;
  localparam int SH_ST  = BITWIDTH_SYS - STAT_W;
  localparam logic [BITWIDTH_SYS-1:0] PAD_IN  = BITWIDTH_SYS'(pad_ones(SH_IN));
  localparam logic [BITWIDTH_SYS-1:0] PAD_OUT = BITWIDTH_SYS'(pad_ones(SH_OUT));

  logic [SIZE_INPUT-1:0][BITWIDTH_IN-1:0]   in_ram_q, in_ram_d;
  logic [SIZE_OUTPUT-1:0][BITWIDTH_OUT-1:0] out_ram_q, out_ram_d;
  logic [BITWIDTH_SYS-1:0]                  data_out_q, data_out_d;

  // Only the top BITWIDTH_IN bits of a write are stored.
  logic unused_data_in;
  assign unused_data_in = ^data_in;

  always_comb begin
    in_ram_d = in_ram_q;
    if (!rnw && wr_allow) begin
      for (int k = 0; k < SIZE_INPUT; k++) begin
        if (adr == BITWIDTH_ADR'(k)) begin
          in_ram_d[k] = data_in[BITWIDTH_SYS-1 -: BITWIDTH_IN];
        end
      end
    end
  end

  always_comb begin
    out_ram_d = out_ram_q;
    if (cap_en) begin
      out_ram_d = cap_vec;
    end
  end

  // Non-read cycles hold the last read value; unmapped addresses read zero.
  always_comb begin
    data_out_d = data_out_q;
    if (rnw) begin
      data_out_d = '0;
      for (int k = 0; k < SIZE_INPUT; k++) begin
        if (adr == BITWIDTH_ADR'(k)) begin
          data_out_d = (BITWIDTH_SYS'(in_ram_q[k]) << SH_IN) | PAD_IN;
        end
      end
      for (int k = 0; k < SIZE_OUTPUT; k++) begin
        if (adr == BITWIDTH_ADR'(SIZE_INPUT + k)) begin
          data_out_d = (BITWIDTH_SYS'(out_ram_q[k]) << SH_OUT) | PAD_OUT;
        end
      end
      if (adr == STATUS_ADR) begin
        data_out_d = BITWIDTH_SYS'(status) << SH_ST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ram_q   <= '0;
      out_ram_q  <= '0;
      data_out_q <= '0;
    end else begin
      in_ram_q   <= in_ram_d;
      out_ram_q  <= out_ram_d;
      data_out_q <= data_out_d;
    end
  end

  assign in_vec   = in_ram_q;
  assign data_out = data_out_q;

endmodule

// File: rtl/skeleton_math_vec.sv
// Test skeleton top: host bus front end, launch/capture sequencer and latency
// counter wrapped around an externally instantiated math/activation DUT.
module skeleton_math_vec
  import skeleton_pkg::*;
#(
  parameter int BITWIDTH_IN   = 8,
  parameter int BITWIDTH_OUT  = 8,
  parameter int BITWIDTH_SYS  = 16,
  parameter int BITWIDTH_ADR  = 6,
  parameter int BITWIDTH_HEAD = 26,
  parameter int SIZE_INPUT    = 4,
  parameter int SIZE_OUTPUT   = 2,
  parameter int MAX_WAIT      = 255,
  parameter int BITWIDTH_CNT  = 8
) (
  input  logic                                CLK_SYS,
  input  logic                                RST,
  input  logic                                EN,
  input  logic                                TRGG_START_CALC,
  input  logic                                RnW,
  input  logic [BITWIDTH_ADR-1:0]             ADR,
  input  logic [BITWIDTH_SYS-1:0]             DATA_IN,
  output logic [BITWIDTH_SYS-1:0]             DATA_OUT,
  output logic [BITWIDTH_HEAD-1:0]            DATA_HEAD,
  output logic                                RDY,
  output logic                                DUT_START,
  output logic [SIZE_INPUT*BITWIDTH_IN-1:0]   DUT_DIN,
  input  logic [SIZE_OUTPUT*BITWIDTH_OUT-1:0] DUT_DOUT,
  input  logic                                DUT_VALID
);

  localparam int STAT_W = BITWIDTH_CNT + 2;
  localparam logic [BITWIDTH_CNT-1:0] MAX_CNT = BITWIDTH_CNT'(MAX_WAIT);
  localparam logic [BITWIDTH_CNT-1:0] SAT_CNT = '1;

  state_e                             state_q, state_d;
  logic [BITWIDTH_CNT-1:0]            lat_q, lat_d, lat_inc;
  logic                               timeout_q, timeout_d;
  logic                               done_q, done_d;
  logic [SIZE_INPUT*BITWIDTH_IN-1:0]  din_q, din_d;
  logic                               valid_q, valid_d;
  logic [SIZE_OUTPUT*BITWIDTH_OUT-1:0] dout_q, dout_d;
  logic                               sync_rst;
  logic                               cap_en;
  logic [SIZE_INPUT*BITWIDTH_IN-1:0]  in_vec;

  assign sync_rst = RST | ~EN;

  skeleton_regfile #(
    .BITWIDTH_IN  (BITWIDTH_IN),
    .BITWIDTH_OUT (BITWIDTH_OUT),
    .BITWIDTH_SYS (BITWIDTH_SYS),
    .BITWIDTH_ADR (BITWIDTH_ADR),
    .SIZE_INPUT   (SIZE_INPUT),
    .SIZE_OUTPUT  (SIZE_OUTPUT),
    .STAT_W       (STAT_W)
  ) u_regfile (
    .clk      (CLK_SYS),
    .rst      (sync_rst),
    .rnw      (RnW),
    .wr_allow (state_q == ST_IDLE),
    .cap_en   (cap_en),
    .adr      (ADR),
    .data_in  (DATA_IN),
    .cap_vec  (dout_q),
    .status   ({timeout_q, done_q, lat_q}),
    .in_vec   (in_vec),
    .data_out (DATA_OUT)
  );

  // DUT_VALID/DUT_DOUT pass through one register so that a DUT answering in the
  // launch cycle itself is seen in the first WAIT cycle and reports latency 1;
  // the count is inclusive of the DUT_START cycle.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    timeout_d = timeout_q;
    done_d    = done_q;
    din_d     = din_q;
    cap_en    = 1'b0;
    valid_d   = DUT_VALID && (state_q == ST_LAUNCH || state_q == ST_WAIT);
    dout_d    = DUT_DOUT;
    lat_inc   = (lat_q == SAT_CNT) ? lat_q : lat_q + BITWIDTH_CNT'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (TRGG_START_CALC) begin
          done_d  = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        din_d   = in_vec;
        state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        lat_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        lat_d = lat_inc;
        if (valid_q) begin
          cap_en    = 1'b1;
          timeout_d = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else if (lat_inc >= MAX_CNT) begin
          cap_en    = 1'b1;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_SYS) begin
    if (sync_rst) begin
      state_q   <= ST_IDLE;
      lat_q     <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      din_q     <= '0;
      valid_q   <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      din_q     <= din_d;
      valid_q   <= valid_d;
      dout_q    <= dout_d;
    end
  end

  assign RDY       = (state_q == ST_IDLE);
  assign DUT_START = (state_q == ST_LAUNCH);
  assign DUT_DIN   = din_q;
  assign DATA_HEAD = BITWIDTH_HEAD'({HEAD_ID, 6'(SIZE_INPUT), 6'(SIZE_OUTPUT),
                                     5'(BITWIDTH_IN), 5'(BITWIDTH_OUT)});

endmodule
